// File: rtl/bin2bcd_display_pkg.sv
// Shared digit codes, FSM state type and BCD helpers for the binary-to-display formatter.
package disp_pkg;

  localparam logic [3:0] DIG_MINUS = 4'b1111;
  localparam logic [3:0] DIG_R     = 4'b1100;
  localparam logic [3:0] DIG_ZERO  = 4'b0000;

  localparam int BCD_W = 12;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  // Double-dabble correction: a nibble of 5..9 would overflow past 9 once doubled.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_display_if.sv
// Request/display bundle between the result producer and the 7-segment formatter.
interface bin2bcd_display_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             is_signed;
  logic             error;
  logic             busy;
  logic             done;
  logic [3:0]       digit3;
  logic [3:0]       digit2;
  logic [3:0]       digit1;
  logic [3:0]       digit0;
  logic [3:0]       en;

  modport master (
    output start, value, is_signed, error,
    input  busy, done, digit3, digit2, digit1, digit0, en
  );

  modport slave (
    input  start, value, is_signed, error,
    output busy, done, digit3, digit2, digit1, digit0, en
  );
endinterface

// File: rtl/bin2bcd_display_dabble_step.sv
// One shift-add-3 iteration: correct each BCD nibble, then shift in the next magnitude bit.
module dabble_step
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic             bit_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj   = {add3(bcd_i[11:8]), add3(bcd_i[7:4]), add3(bcd_i[3:0])};
    bcd_o = {adj[BCD_W-2:0], bit_i};
  end

endmodule

// File: rtl/bin2bcd_display.sv
// Sequential binary-to-BCD formatter feeding four 7-segment decoders (sign, hundreds, tens, units).
module bin2bcd_display
  import disp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  bin2bcd_display_if.slave bus
);

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [3:0][3:0]        dig_q, dig_d;
  logic [3:0]             en_q, en_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [WIDTH-1:0]       mag_q, mag_d;
  logic                   neg_q, neg_d;
  logic                   err_q, err_d;
  logic [BCD_W-1:0]       step_bcd;

  // Returns {digit3, digit2, digit1, digit0, en} for the decoders.
  function automatic logic [19:0] format_digits(input logic err, input logic neg,
                                                input logic [BCD_W-1:0] bcd);
    logic [3:0] hun, ten, uni;
    logic       hun_nz, ten_nz;
    hun    = bcd[11:8];
    ten    = bcd[7:4];
    uni    = bcd[3:0];
    hun_nz = (hun != 4'd0);
    ten_nz = (ten != 4'd0);
    if (err)
      return {DIG_MINUS, DIG_R, DIG_R, DIG_MINUS, 4'b1111};
    return {(neg ? DIG_MINUS : DIG_ZERO), hun, ten, uni,
            neg, hun_nz, hun_nz | ten_nz, 1'b1};
  endfunction

  dabble_step u_step (
    .bcd_i (bcd_q),
    .bit_i (mag_q[WIDTH-1]),
    .bcd_o (step_bcd)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dig_d   = dig_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_d   = bus.is_signed & bus.value[WIDTH-1];
          // Negating the signed minimum wraps to itself, which read unsigned is the right magnitude.
          mag_d   = neg_d ? (~bus.value + WIDTH'(1)) : bus.value;
          err_d   = bus.error;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = step_bcd;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = FORMAT;
      end
      FORMAT: begin
        {dig_d, en_d} = format_digits(err_q, neg_q, bcd_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
    end
  end

  // Working registers are always reloaded at start, so they carry no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    bcd_q <= bcd_d;
    mag_q <= mag_d;
    neg_q <= neg_d;
    err_q <= err_d;
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digit3 = dig_q[3];
  assign bus.digit2 = dig_q[2];
  assign bus.digit1 = dig_q[1];
  assign bus.digit0 = dig_q[0];
  assign bus.en     = en_q;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Self-checking bench for bin2bcd_display: directed cases plus random conversions vs. an arithmetic model.
module tb_bin2bcd_display;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bin2bcd_display_if #(.WIDTH(W)) bus ();

  bin2bcd_display #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {digit3, digit2, digit1, digit0, en} from decimal arithmetic.
  function automatic logic [19:0] model(input logic [W-1:0] v, input logic s, input logic e);
    int   m, h, t, u;
    logic n;
    if (e) return {4'hF, 4'hC, 4'hC, 4'hF, 4'hF};
    n = s & v[W-1];
    m = n ? (1 << W) - int'(v) : int'(v);
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    return {(n ? 4'hF : 4'h0), 4'(h), 4'(t), 4'(u), n, (h != 0), (h != 0) || (t != 0), 1'b1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [19:0] exp);
    check({tag, "_d3"}, 32'(bus.digit3), 32'(exp[19:16]));
    check({tag, "_d2"}, 32'(bus.digit2), 32'(exp[15:12]));
    check({tag, "_d1"}, 32'(bus.digit1), 32'(exp[11:8]));
    check({tag, "_d0"}, 32'(bus.digit0), 32'(exp[7:4]));
    check({tag, "_en"}, 32'(bus.en),     32'(exp[3:0]));
  endtask

  // One conversion; inputs are scrambled after capture. poke>0 raises start
  // for the edge numbered poke (relative to the capture edge 0).
  task automatic run_conv(input string tag, input logic [W-1:0] v, input logic s,
                          input logic e, input int poke);
    logic [19:0] exp;
    int          dones;
    int          done_cyc;
    exp = model(v, s, e);
    @(negedge clk);
    bus.start = 1'b1; bus.value = v; bus.is_signed = s; bus.error = e;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.value = W'($urandom); bus.is_signed = 1'($urandom); bus.error = 1'($urandom);
    check({tag, "_busy_c0"}, 32'(bus.busy), 32'd1);
    dones = 0;
    done_cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      bus.start = (k == poke);
      @(posedge clk); #1;
      if (k == 8) check({tag, "_busy_c8"}, 32'(bus.busy), 32'd1);
      if (k == 9) check({tag, "_busy_c9"}, 32'(bus.busy), 32'd0);
      if (bus.done === 1'b1) begin
        dones++;
        done_cyc = k;
        check_outputs(tag, exp);
      end
    end
    bus.start = 1'b0;
    check({tag, "_ndone"}, 32'(dones), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'd9);
    check_outputs({tag, "_hold"}, exp);
  endtask

  initial begin
    int          dones;
    int          d1, d2;
    logic [W-1:0] rv;
    logic        rs, re;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.value = '0; bus.is_signed = 1'b0; bus.error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_outputs("rst", 20'h0);
    @(negedge clk);
    reset = 1'b0;

    run_conv("t1_255", 8'd255, 1'b0, 1'b0, 0);
    run_conv("t2_m1", 8'hFF, 1'b1, 1'b0, 0);
    run_conv("t3_m128", 8'h80, 1'b1, 1'b0, 0);
    run_conv("t4_zero", 8'd0, 1'b0, 1'b0, 0);
    run_conv("t4_7", 8'd7, 1'b0, 1'b0, 0);
    run_conv("t4_40", 8'd40, 1'b0, 1'b0, 0);
    run_conv("t5_err", 8'd123, 1'b1, 1'b1, 4);
    run_conv("us_msb", 8'd200, 1'b0, 1'b0, 7);

    // Reset during SHIFT aborts with a blank display and no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.value = 8'd200; bus.is_signed = 1'b0; bus.error = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_en", 32'(bus.en), 32'd0);
    check("t6_d0", 32'(bus.digit0), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    check("t6_nodone", 32'(dones), 32'd0);
    run_conv("t6_99", 8'd99, 1'b0, 1'b0, 0);

    // start held high: back-to-back conversions every W+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.value = 8'd123; bus.is_signed = 1'b0; bus.error = 1'b0;
    @(posedge clk); #1;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    bus.start = 1'b0;
    check("held_first", 32'(d1), 32'd9);
    check("held_second", 32'(d2), 32'd19);
    check_outputs("held", model(8'd123, 1'b0, 1'b0));
    repeat (12) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      rv = W'($urandom);
      rs = 1'($urandom);
      re = ($urandom_range(0, 7) == 0);
      run_conv($sformatf("rnd%0d", i), rv, rs, re, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
